// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared encodings for the memory stage.
//   - Writeback select codes carried on mulSel (11 is treated like ALU).
//   - Bus FSM state encoding (2-bit).
package mem_stage_pkg;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } mem_state_t;

endpackage

// File: rtl/mem_bus_fsm.sv
// mem_bus_fsm: data-memory req/ack sequencer for the memory stage.
// Ports:
//   clk, reset (async, active-low)
//   access          - current EX/MEM op needs the bus (load or store)
//   wrEn            - access is a store
//   addr, wrData    - address and store data to launch
//   busReq/busWe/busAddr/busWrData - registered bus request fields
//   busAck, busRdData               - completion pulse and load data
//   loadData        - load data captured on busAck
//   stall           - upstream hold (IDLE & access) | WAIT
//   state           - current FSM state, exposed for observation
// Handshake: busReq rises on the edge leaving IDLE and stays high with all
// bus fields stable until the cycle in which busAck=1; that edge drops
// busReq and captures busRdData. busAck in any other state is ignored.
module mem_bus_fsm
  import mem_stage_pkg::*;
#(
  parameter int BIT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 access,
  input  logic                 wrEn,
  input  logic [BIT_WIDTH-1:0] addr,
  input  logic [BIT_WIDTH-1:0] wrData,
  output logic                 busReq,
  output logic                 busWe,
  output logic [BIT_WIDTH-1:0] busAddr,
  output logic [BIT_WIDTH-1:0] busWrData,
  input  logic                 busAck,
  input  logic [BIT_WIDTH-1:0] busRdData,
  output logic [BIT_WIDTH-1:0] loadData,
  output logic                 stall,
  output mem_state_t           state
);

  mem_state_t stateNext;
  logic       issue;
  logic       capture;
  logic       stallRaw;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    stallRaw  = 1'b0;
    issue     = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          stateNext = WAIT;
          stallRaw  = 1'b1;
          issue     = 1'b1;
        end
      end
      WAIT: begin
        stallRaw = 1'b1;
        if (busAck) begin
          capture   = 1'b1;
          stateNext = DONE;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Nothing is registered while reset is held, so stall is forced low then;
  // upstream sees a clean "not holding" during reset.
  assign stall = reset & stallRaw;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busReq    <= 1'b0;
      busWe     <= 1'b0;
      busAddr   <= '0;
      busWrData <= '0;
      loadData  <= '0;
    end else begin
      if (issue) begin
        busReq    <= 1'b1;
        busWe     <= wrEn;
        busAddr   <= addr;
        busWrData <= wrData;
      end
      if (capture) begin
        busReq   <= 1'b0;
        loadData <= busRdData;
      end
    end
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory stage of the 32-bit pipeline, fed by the EX/MEM register.
// Launches loads/stores on a req/ack bus (via mem_bus_fsm), stalls upstream
// while an access is outstanding, selects the writeback value and holds the
// MEM/WB registers.
// Ports:
//   clk, reset (async, active-low)
//   regWrEnIn, regWrAddrIn, memWrEnIn, mulSelIn, aluOutIn, dataInIn, PCIn
//                                  - EX/MEM outputs
//   busReq, busWe, busAddr, busWrData, busAck, busRdData - data memory bus
//   stall                          - upstream hold
//   wbRegWrEn, wbRegWrAddr, wbData - MEM/WB registers
//   fsmState                       - bus FSM state, for observation
//   misalignErr                    - only with MEM_STAGE_MISALIGN_TRAP_EN:
//                                    one-cycle pulse for a trapped access
// Build option: `define MEM_STAGE_MISALIGN_TRAP_EN to trap accesses whose
// address has nonzero low two bits instead of sending them to the bus.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter int WB_SEL_W  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 regWrEnIn,
  input  logic [3:0]           regWrAddrIn,
  input  logic                 memWrEnIn,
  input  logic [WB_SEL_W-1:0]  mulSelIn,
  input  logic [BIT_WIDTH-1:0] aluOutIn,
  input  logic [BIT_WIDTH-1:0] dataInIn,
  input  logic [BIT_WIDTH-1:0] PCIn,
  output logic                 busReq,
  output logic                 busWe,
  output logic [BIT_WIDTH-1:0] busAddr,
  output logic [BIT_WIDTH-1:0] busWrData,
  input  logic                 busAck,
  input  logic [BIT_WIDTH-1:0] busRdData,
  output logic                 stall,
  output logic                 wbRegWrEn,
  output logic [3:0]           wbRegWrAddr,
  output logic [BIT_WIDTH-1:0] wbData,
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  output logic                 misalignErr,
`endif
  output mem_state_t           fsmState
);

  logic                 accessRaw;
  logic                 access;
  logic                 misaligned;
  logic [BIT_WIDTH-1:0] loadData;
  logic [BIT_WIDTH-1:0] wbSelData;

  assign accessRaw = memWrEnIn | (mulSelIn == WB_MEM);

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  assign misaligned = accessRaw & (aluOutIn[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // A trapped access never reaches the bus, so it never stalls.
  assign access = accessRaw & ~misaligned;

  mem_bus_fsm #(
    .BIT_WIDTH(BIT_WIDTH)
  ) u_bus_fsm (
    .clk       (clk),
    .reset     (reset),
    .access    (access),
    .wrEn      (memWrEnIn),
    .addr      (aluOutIn),
    .wrData    (dataInIn),
    .busReq    (busReq),
    .busWe     (busWe),
    .busAddr   (busAddr),
    .busWrData (busWrData),
    .busAck    (busAck),
    .busRdData (busRdData),
    .loadData  (loadData),
    .stall     (stall),
    .state     (fsmState)
  );

  always_comb begin
    wbSelData = aluOutIn;
    case (mulSelIn)
      WB_MEM:  wbSelData = loadData;
      WB_PC:   wbSelData = PCIn;
      default: wbSelData = aluOutIn;
    endcase
  end

  // Stall edges push a bubble into WB; data and address hold so WB keeps
  // showing the last completed op.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wbRegWrEn   <= 1'b0;
      wbRegWrAddr <= '0;
      wbData      <= '0;
    end else if (stall) begin
      wbRegWrEn <= 1'b0;
    end else begin
      wbRegWrEn   <= regWrEnIn & ~misaligned;
      wbRegWrAddr <= regWrAddrIn;
      wbData      <= wbSelData;
    end
  end

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) misalignErr <= 1'b0;
    else        misalignErr <= misaligned & ~stall;
  end
`endif

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk;
  logic        reset;
  logic        regWrEnIn;
  logic [3:0]  regWrAddrIn;
  logic        memWrEnIn;
  logic [1:0]  mulSelIn;
  logic [31:0] aluOutIn;
  logic [31:0] dataInIn;
  logic [31:0] PCIn;
  logic        busReq;
  logic        busWe;
  logic [31:0] busAddr;
  logic [31:0] busWrData;
  logic        busAck;
  logic [31:0] busRdData;
  logic        stall;
  logic        wbRegWrEn;
  logic [3:0]  wbRegWrAddr;
  logic [31:0] wbData;
  mem_state_t  fsmState;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  logic        misalignErr;
`endif

  int total_cnt = 0;
  int bad_cnt   = 0;

  mem_stage #(.BIT_WIDTH(32), .WB_SEL_W(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .regWrEnIn   (regWrEnIn),
    .regWrAddrIn (regWrAddrIn),
    .memWrEnIn   (memWrEnIn),
    .mulSelIn    (mulSelIn),
    .aluOutIn    (aluOutIn),
    .dataInIn    (dataInIn),
    .PCIn        (PCIn),
    .busReq      (busReq),
    .busWe       (busWe),
    .busAddr     (busAddr),
    .busWrData   (busWrData),
    .busAck      (busAck),
    .busRdData   (busRdData),
    .stall       (stall),
    .wbRegWrEn   (wbRegWrEn),
    .wbRegWrAddr (wbRegWrAddr),
    .wbData      (wbData),
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    .misalignErr (misalignErr),
`endif
    .fsmState    (fsmState)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic we, input logic [3:0] wa, input logic mw,
                        input logic [1:0] sel, input logic [31:0] alu,
                        input logic [31:0] din, input logic [31:0] pc);
    regWrEnIn   = we;
    regWrAddrIn = wa;
    memWrEnIn   = mw;
    mulSelIn    = sel;
    aluOutIn    = alu;
    dataInIn    = din;
    PCIn        = pc;
    #1;
  endtask

  task automatic set_bubble();
    set_op(1'b0, 4'd0, 1'b0, 2'b00, 32'd0, 32'd0, 32'd0);
  endtask

  // scenarios
  task automatic test_reset();
    reset = 1'b0;
    busAck = 1'b0;
    busRdData = 32'd0;
    for (int i = 0; i < 4; i++) begin
      set_op(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), $urandom, $urandom, $urandom);
      busAck = 1'($urandom_range(0, 1));
      busRdData = $urandom;
      tick();
      total_cnt++;
      if ({busReq, busWe, busAddr, busWrData, wbRegWrEn, wbRegWrAddr, wbData, stall} !== '0) begin
        bad_cnt++;
        $display("FAIL reset_outputs got req=%0b we=%0b addr=%h wd=%h wen=%0b wa=%0d wd=%h stall=%0b want all 0",
                 busReq, busWe, busAddr, busWrData, wbRegWrEn, wbRegWrAddr, wbData, stall);
      end
      total_cnt++;
      if (fsmState !== IDLE) begin
        bad_cnt++;
        $display("FAIL reset_state got=%0d want=%0d", fsmState, IDLE);
      end
    end
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    total_cnt++;
    if (misalignErr !== 1'b0) begin
      bad_cnt++;
      $display("FAIL reset_misalign got=%0b want=0", misalignErr);
    end
`endif
    busAck = 1'b0;
    set_bubble();
    reset = 1'b1;
    tick();
    // ALU op after release
    set_op(1'b1, 4'd3, 1'b0, 2'b00, 32'h0000_0042, 32'h0, 32'h0);
    total_cnt++;
    if (stall !== 1'b0) begin
      bad_cnt++;
      $display("FAIL alu_stall got=%0b want=0", stall);
    end
    tick();
    set_bubble();
    total_cnt++;
    if ({wbRegWrEn, wbRegWrAddr, wbData} !== {1'b1, 4'd3, 32'h42}) begin
      bad_cnt++;
      $display("FAIL alu_wb got en=%0b addr=%0d data=%h want en=1 addr=3 data=42",
               wbRegWrEn, wbRegWrAddr, wbData);
    end
  endtask

  task automatic test_load();
    // arrival cycle
    set_op(1'b1, 4'd5, 1'b0, 2'b01, 32'h100, 32'h0, 32'h0);
    total_cnt++;
    if (stall !== 1'b1) begin
      bad_cnt++;
      $display("FAIL load_stall_c0 got=%0b want=1", stall);
    end
    tick(); // first WAIT cycle, no ack
    total_cnt++;
    if ({busReq, busWe, busAddr, stall, wbRegWrEn} !== {1'b1, 1'b0, 32'h100, 1'b1, 1'b0}) begin
      bad_cnt++;
      $display("FAIL load_req_c1 got req=%0b we=%0b addr=%h stall=%0b wen=%0b want 1 0 100 1 0",
               busReq, busWe, busAddr, stall, wbRegWrEn);
    end
    tick(); // second WAIT cycle, ack
    busAck = 1'b1;
    busRdData = 32'hDEAD_BEEF;
    #1;
    total_cnt++;
    if ({busReq, busAddr, stall, wbRegWrEn, wbData} !== {1'b1, 32'h100, 1'b1, 1'b0, 32'h42}) begin
      bad_cnt++;
      $display("FAIL load_req_c2 got req=%0b addr=%h stall=%0b wen=%0b wd=%h want 1 100 1 0 42",
               busReq, busAddr, stall, wbRegWrEn, wbData);
    end
    tick(); // DONE
    busAck = 1'b0;
    busRdData = 32'h0;
    #1;
    total_cnt++;
    if ({busReq, stall, wbRegWrEn, fsmState} !== {1'b0, 1'b0, 1'b0, DONE}) begin
      bad_cnt++;
      $display("FAIL load_done_c3 got req=%0b stall=%0b wen=%0b st=%0d want 0 0 0 %0d",
               busReq, stall, wbRegWrEn, fsmState, DONE);
    end
    tick();
    set_bubble();
    total_cnt++;
    if ({wbRegWrEn, wbRegWrAddr, wbData, fsmState} !== {1'b1, 4'd5, 32'hDEAD_BEEF, IDLE}) begin
      bad_cnt++;
      $display("FAIL load_wb_c4 got en=%0b addr=%0d data=%h st=%0d want 1 5 deadbeef %0d",
               wbRegWrEn, wbRegWrAddr, wbData, fsmState, IDLE);
    end
    tick();
  endtask

  task automatic test_store();
    set_op(1'b0, 4'd7, 1'b1, 2'b00, 32'h200, 32'h1234_5678, 32'h0);
    total_cnt++;
    if (stall !== 1'b1) begin
      bad_cnt++;
      $display("FAIL store_stall_c0 got=%0b want=1", stall);
    end
    tick();
    busAck = 1'b1;
    #1;
    total_cnt++;
    if ({busReq, busWe, busAddr, busWrData, wbRegWrEn} !== {1'b1, 1'b1, 32'h200, 32'h1234_5678, 1'b0}) begin
      bad_cnt++;
      $display("FAIL store_req got req=%0b we=%0b addr=%h wd=%h wen=%0b want 1 1 200 12345678 0",
               busReq, busWe, busAddr, busWrData, wbRegWrEn);
    end
    tick(); // DONE
    busAck = 1'b0;
    #1;
    total_cnt++;
    if ({busReq, stall, wbRegWrEn} !== 3'b000) begin
      bad_cnt++;
      $display("FAIL store_done got req=%0b stall=%0b wen=%0b want 0 0 0", busReq, stall, wbRegWrEn);
    end
    tick();
    set_bubble();
    total_cnt++;
    if ({wbRegWrEn, wbRegWrAddr, wbData} !== {1'b0, 4'd7, 32'h200}) begin
      bad_cnt++;
      $display("FAIL store_wb got en=%0b addr=%0d data=%h want 0 7 200", wbRegWrEn, wbRegWrAddr, wbData);
    end
    tick();
  endtask

  task automatic test_link();
    // stray ack outside WAIT must be ignored
    busAck = 1'b1;
    busRdData = 32'hBAD0_BAD0;
    set_op(1'b1, 4'd15, 1'b0, 2'b10, 32'h999, 32'h0, 32'h0000_0040);
    total_cnt++;
    if (stall !== 1'b0) begin
      bad_cnt++;
      $display("FAIL link_stall got=%0b want=0", stall);
    end
    tick();
    busAck = 1'b0;
    set_bubble();
    total_cnt++;
    if ({wbRegWrEn, wbRegWrAddr, wbData, busReq, fsmState} !== {1'b1, 4'd15, 32'h40, 1'b0, IDLE}) begin
      bad_cnt++;
      $display("FAIL link_wb got en=%0b addr=%0d data=%h req=%0b st=%0d want 1 15 40 0 %0d",
               wbRegWrEn, wbRegWrAddr, wbData, busReq, fsmState, IDLE);
    end
    // ALU select 11 behaves as ALU
    set_op(1'b1, 4'd2, 1'b0, 2'b11, 32'hCAFE_0001, 32'h0, 32'h44);
    tick();
    set_bubble();
    total_cnt++;
    if ({wbRegWrEn, wbRegWrAddr, wbData} !== {1'b1, 4'd2, 32'hCAFE_0001}) begin
      bad_cnt++;
      $display("FAIL sel11_wb got en=%0b addr=%0d data=%h want 1 2 cafe0001", wbRegWrEn, wbRegWrAddr, wbData);
    end
  endtask

  task automatic test_back_to_back();
    // load with immediate ack, then a second load right after DONE
    set_op(1'b1, 4'd8, 1'b0, 2'b01, 32'h400, 32'h0, 32'h0);
    tick();
    busAck = 1'b1;
    busRdData = 32'h1111_2222;
    tick(); // DONE
    busAck = 1'b0;
    busRdData = 32'h0;
    #1;
    tick(); // first op written back; second op arrives
    set_op(1'b1, 4'd9, 1'b0, 2'b01, 32'h404, 32'h0, 32'h0);
    total_cnt++;
    if ({wbRegWrEn, wbRegWrAddr, wbData, stall} !== {1'b1, 4'd8, 32'h1111_2222, 1'b1}) begin
      bad_cnt++;
      $display("FAIL b2b_first got en=%0b addr=%0d data=%h stall=%0b want 1 8 11112222 1",
               wbRegWrEn, wbRegWrAddr, wbData, stall);
    end
    tick();
    total_cnt++;
    if ({busReq, busAddr, fsmState} !== {1'b1, 32'h404, WAIT}) begin
      bad_cnt++;
      $display("FAIL b2b_req got req=%0b addr=%h st=%0d want 1 404 %0d", busReq, busAddr, fsmState, WAIT);
    end
    busAck = 1'b1;
    busRdData = 32'h3333_4444;
    tick();
    busAck = 1'b0;
    #1;
    tick();
    set_bubble();
    total_cnt++;
    if ({wbRegWrEn, wbRegWrAddr, wbData} !== {1'b1, 4'd9, 32'h3333_4444}) begin
      bad_cnt++;
      $display("FAIL b2b_second got en=%0b addr=%0d data=%h want 1 9 33334444", wbRegWrEn, wbRegWrAddr, wbData);
    end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    set_op(1'b1, 4'd6, 1'b0, 2'b01, 32'h300, 32'h0, 32'h0);
    tick();
    total_cnt++;
    if (busReq !== 1'b1) begin
      bad_cnt++;
      $display("FAIL midrst_req got=%0b want=1", busReq);
    end
    #2;
    reset = 1'b0;
    #1;
    total_cnt++;
    if ({busReq, fsmState, stall} !== {1'b0, IDLE, 1'b0}) begin
      bad_cnt++;
      $display("FAIL midrst_async got req=%0b st=%0d stall=%0b want 0 %0d 0", busReq, fsmState, stall, IDLE);
    end
    set_bubble();
    tick();
    reset = 1'b1;
    tick();
    busAck = 1'b1;
    busRdData = 32'h5555_AAAA;
    tick();
    busAck = 1'b0;
    #1;
    total_cnt++;
    if ({fsmState, busReq, wbRegWrEn, wbData} !== {IDLE, 1'b0, 1'b0, 32'h0}) begin
      bad_cnt++;
      $display("FAIL midrst_stale_ack got st=%0d req=%0b wen=%0b wd=%h want %0d 0 0 0",
               fsmState, busReq, wbRegWrEn, wbData, IDLE);
    end
  endtask

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  task automatic test_misalign();
    set_op(1'b1, 4'd9, 1'b0, 2'b01, 32'h102, 32'h0, 32'h0);
    total_cnt++;
    if (stall !== 1'b0) begin
      bad_cnt++;
      $display("FAIL misalign_stall got=%0b want=0", stall);
    end
    tick();
    set_bubble();
    total_cnt++;
    if ({busReq, misalignErr, wbRegWrEn} !== 3'b010) begin
      bad_cnt++;
      $display("FAIL misalign_pulse got req=%0b err=%0b wen=%0b want 0 1 0", busReq, misalignErr, wbRegWrEn);
    end
    tick();
    total_cnt++;
    if ({misalignErr, busReq} !== 2'b00) begin
      bad_cnt++;
      $display("FAIL misalign_clear got err=%0b req=%0b want 0 0", misalignErr, busReq);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_store();
    test_link();
    test_back_to_back();
    test_reset_mid_wait();
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    test_misalign();
`endif
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 32-bit pipeline. Sits directly downstream of the EX/MEM pipeline register and consumes its outputs: reg write enable and address, store data, memory write enable, writeback select, ALU result and PC.
- Performs data-memory loads and stores over a req/ack bus. Stalls the upstream pipeline while an access is outstanding.
- Selects the writeback value and registers it as the MEM/WB boundary.

Parameters:
BIT_WIDTH, 32, datapath/address width
WB_SEL_W, 2, writeback select width (matches mulSel)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
regWrEnIn  in  1  register write enable from EX/MEM
regWrAddrIn  in  4  destination register from EX/MEM
memWrEnIn  in  1  store request from EX/MEM
mulSelIn  in  2  writeback select: 00 ALU, 01 load data, 10 PC, 11 ALU
aluOutIn  in  BIT_WIDTH  ALU result, used as memory address for loads and stores
dataInIn  in  BIT_WIDTH  store data
PCIn  in  BIT_WIDTH  PC value for link writeback
busReq  out  1  memory request
busWe  out  1  1 = write, 0 = read
busAddr  out  BIT_WIDTH  memory address
busWrData  out  BIT_WIDTH  store data to memory
busAck  in  1  memory completion, single-cycle pulse
busRdData  in  BIT_WIDTH  load data, valid when busAck=1
stall  out  1  1 = upstream holds (EX/MEM buffWrEn is driven low)
wbRegWrEn  out  1  registered write enable to the register file
wbRegWrAddr  out  4  registered destination register
wbData  out  BIT_WIDTH  registered writeback value

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low.
- Reset (reset=0, asynchronous): state=IDLE; busReq, busWe, busAddr, busWrData, wbRegWrEn, wbRegWrAddr and wbData all 0. Reset mid-access abandons the transaction; a later busAck is ignored.
- access = memWrEnIn | (mulSelIn==01). A bubble (regWrEn=0, memWrEn=0, mulSel≠01) is not an access.
- FSM states: IDLE, WAIT, DONE.
  - IDLE & !access: stay in IDLE. Writeback registers load on this edge.
  - IDLE & access: go to WAIT. Register busReq=1, busWe=memWrEnIn, busAddr=aluOutIn, busWrData=dataInIn.
  - WAIT: hold busReq and bus fields stable until busAck. On busAck, capture busRdData into an internal load register, drop busReq, and go to DONE.
  - DONE: go to IDLE. Writeback registers load on this edge.
- stall = (IDLE & access) | WAIT. Combinational. stall=0 in DONE, so EX/MEM advances on the same edge that wb captures the completed op.
- Writeback registers:
  - On every edge with stall=0 (and not reset): load wbRegWrAddr=regWrAddrIn and wbRegWrEn=regWrEnIn. wbData is selected by mulSel: 00/11 → aluOutIn, 01 → load register, 10 → PCIn.
  - On edges with stall=1: load wbRegWrEn=0 (bubble). wbData and wbRegWrAddr hold.
- Latency:
  - Non-access op: wb valid 1 cycle after arrival.
  - Access with ack in the first WAIT cycle: wb valid 3 cycles after arrival. Each extra wait cycle adds 1.
- A store with regWrEnIn=1 is legal and writes aluOutIn to the register file.
- busAck outside WAIT is ignored.
- Back-to-back accesses: after DONE→IDLE the next access re-enters WAIT. There is no overlap; at most one outstanding request.
- Widths: no arithmetic. All data paths are BIT_WIDTH; no truncation.

Optional Feature:
- Macro: MEM_STAGE_MISALIGN_TRAP_EN.
- Defined:
  - An access with aluOutIn[1:0]≠00 issues no bus request and does not stall.
  - The wb edge loads wbRegWrEn=0.
  - New output misalignErr is pulsed high for exactly one cycle, on the cycle after arrival, together with that suppressed writeback.
- Undefined: no misalignErr port. The address is passed to busAddr unmodified, low bits included.

Decomposition:
- Shared package: writeback-select encodings (WB_ALU=00, WB_MEM=01, WB_PC=10) and the FSM state encoding (IDLE, WAIT, DONE; 2-bit).
- One sub-module, mem_bus_fsm: state register, bus request/field registers, load-data capture and stall generation.
- Writeback mux and MEM/WB registers stay in mem_stage.

Test Plan:
- Reset: hold reset=0 with random inputs → all outputs 0 and stall=0. Release; ALU op (regWrEn=1, addr 3, aluOut=0x0000_0042, mulSel=00) → next cycle wbRegWrEn=1, wbRegWrAddr=3, wbData=0x42.
- Load, ack after 2 WAIT cycles:
  - Input: mulSel=01, aluOut=0x100, regWrAddr=5; busRdData=0xDEAD_BEEF.
  - busReq=1, busWe=0, busAddr=0x100 from cycle+1.
  - stall=1 from arrival through the ack cycle.
  - wbData=0xDEAD_BEEF, wbRegWrEn=1, wbRegWrAddr=5 at arrival+4.
  - wbRegWrEn=0 in all stall cycles.
- Store: memWrEn=1, aluOut=0x200, dataIn=0x1234_5678, regWrEn=0, immediate ack → busWe=1, busAddr=0x200, busWrData=0x1234_5678; wbRegWrEn stays 0; stall drops in DONE.
- Link: mulSel=10, PC=0x0000_0040, regWrAddr=15 → wbData=0x40 next cycle, no busReq.
- Reset mid-WAIT: pull reset low while busReq=1, then pulse busAck after release → state IDLE, busReq=0, no writeback from the stale ack.
- With MEM_STAGE_MISALIGN_TRAP_EN: load at aluOut=0x102 → no busReq, stall=0, misalignErr=1 for one cycle, wbRegWrEn=0.
